proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
Moore control FSM that sequences the 16-bit programmable processor datapath: instruction memory, IR, PC, register file, data memory and ALU. Each instruction runs Fetch -> Decode -> Execute. The unit drives every datapath strobe and select, and exports State/NextState for debug. It sits inside the processor top, next to the datapath, and sees only the IR contents.

Parameters:
STATE_W, 8, width of State/NextState debug outputs
PC_W, 8, program counter width (informational; unit drives no PC value)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
IR  in  16  current instruction register contents
Step_En  in  1  1 = single-step mode
Step  in  1  advance pulse, used only when Step_En=1
PC_Clr  out  1  clear PC to 0
PC_Up  out  1  increment PC
IR_Ld  out  1  load IR from instruction memory
D_Addr  out  8  data memory address
D_Wr  out  1  data memory write enable
RF_s  out  2  RF write-data select: 00 ALU, 01 D mem, 10 immediate
RF_Imm  out  8  immediate (IR[11:4]), zero-extended by the datapath
RF_W_Addr  out  4  RF write address
RF_W_En  out  1  RF write enable
RF_Ra_Addr  out  4  RF read port A address
RF_Rb_Addr  out  4  RF read port B address
ALU_Sel  out  3  000 zero, 001 A+B, 010 A-B, 011 pass A
Halted  out  1  1 while in Halt
State  out  8  current state code
NextState  out  8  combinational next state

Behaviour:
- Clk and Reset: one clock, Clk. Reset is synchronous and active-high: on a rising Clk edge with Reset=1, state <= Init. This holds from any state, including mid-instruction. An abandoned instruction performs no further writes.
- State codes:
  - Init=00, Fetch=01, Decode=02, NoOp=03
  - LoadA=04, LoadB=05, Store=06
  - Add=07, Sub=08, Halt=09, LoadC=0A, Wait=0B
- Outputs are Moore, decoded from the registered state. Every strobe is 0 and every select/address is 0 unless listed below for a state.
- Init: PC_Clr=1. Next state is Fetch.
- Fetch: IR_Ld=1, PC_Up=1. Next state is Decode.
- Decode: addresses driven early so synchronous memory/RF reads are valid next cycle. Next state by IR[15:12]:
  - 0 -> NoOp
  - 1 -> Store
  - 2 -> LoadA
  - 3 -> Add
  - 4 -> Sub
  - 5 -> LoadC
  - 6 -> Halt
  - 7..F -> NoOp (illegal opcodes are ignored)
- Instruction fields:
  - STORE: Ra=IR[11:8], addr=IR[7:0]
  - LOAD: addr=IR[11:4], Rd=IR[3:0]
  - ADD/SUB: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0]
  - LOADC: imm=IR[11:4], Rd=IR[3:0]
- Decode drives D_Addr and RF_Ra_Addr/RF_Rb_Addr from these fields.
- LoadA: D_Addr=IR[11:4]. Next state is LoadB (one extra cycle for synchronous RAM read).
- LoadB: D_Addr held, RF_s=01, RF_W_Addr=IR[3:0], RF_W_En=1.
- Store: D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], D_Wr=1.
- Add / Sub: RF_Ra_Addr and RF_Rb_Addr from fields, ALU_Sel=001 (Add) or 010 (Sub), RF_s=00, RF_W_Addr=IR[3:0], RF_W_En=1.
- LoadC: RF_s=10, RF_Imm=IR[11:4], RF_W_Addr=IR[3:0], RF_W_En=1.
- After any Execute state (NoOp, LoadB, Store, Add, Sub, LoadC):
  - Step_En=0 -> Fetch.
  - Step_En=1 -> Wait. Wait holds all outputs at 0 and goes to Fetch on the first cycle with Step=1.
- Step level and Step_En changes are sampled only in Wait and in Execute states.
- Halt: Halted=1. Absorbing; only Reset leaves it. Step is ignored.
- Cycle counts, from the Fetch cycle to the next Fetch, with Step_En=0:
  - LOAD: 4 cycles
  - all other instructions: 3 cycles
- Reset asserted on the same edge as a Store or RF write: the write strobe for that cycle was already presented. Reset only prevents later cycles.
- NextState is a pure function of state, IR, Step_En, Step and Reset. Reset=1 forces NextState=Init.

Decomposition:
- Package proc_isa_pkg holds:
  - opcode constants (OP_NOOP..OP_HALT)
  - state code localparams
  - ALU_Sel and RF_s encodings
  - IR field bit positions
- The datapath shares this package.
- One sub-module, proc_ir_decode: combinational split of IR into opcode/Ra/Rb/Rd/addr/imm. The FSM stays in proc_control_unit.

Test Plan:
- Reset=1 for 1 cycle, then IR=0x5 2A 3 (LOADC 0x2A -> R3):
  - State sequence 00,01,02,0A,01.
  - In 0A: RF_W_En=1, RF_W_Addr=3, RF_s=10, RF_Imm=0x2A.
- IR=0x2 1B 5 (LOAD D[0x1B] -> R5):
  - States 01,02,04,05.
  - D_Addr=0x1B in 02/04/05; RF_W_En=1 only in 05.
- IR=0x3 12 4 (ADD R4=R1+R2), then IR=0x4 12 4:
  - ALU_Sel=001 in state 07, then 010 in state 08.
  - Ra=1, Rb=2, W_Addr=4, W_En=1.
- IR=0x1 3 40 (STORE R3 -> D[0x40]):
  - State 06 with D_Wr=1, D_Addr=0x40, RF_Ra_Addr=3.
  - RF_W_En=0.
- IR=0x6000:
  - Reaches 09, Halted=1, stays there 20 cycles with Step toggling.
  - Reset=1 -> Init next edge, PC_Clr=1.
- Step_En=1, IR=NOOP:
  - After 03, state holds 0B for 5 cycles.
  - Step=1 -> 01 next edge.
  - Reset asserted during LoadA -> next state 00, no RF_W_En pulse seen.

Source files
------------

// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the 16-bit processor: opcodes, control-FSM state codes,
// datapath select encodings and instruction field positions.
package proc_isa_pkg;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_LOADC = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'h6;

    typedef enum logic [7:0] {
        ST_INIT   = 8'h00,
        ST_FETCH  = 8'h01,
        ST_DECODE = 8'h02,
        ST_NOOP   = 8'h03,
        ST_LOADA  = 8'h04,
        ST_LOADB  = 8'h05,
        ST_STORE  = 8'h06,
        ST_ADD    = 8'h07,
        ST_SUB    = 8'h08,
        ST_HALT   = 8'h09,
        ST_LOADC  = 8'h0A,
        ST_WAIT   = 8'h0B
    } state_e;

    localparam logic [2:0] ALU_ZERO  = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_PASSA = 3'b011;

    localparam logic [1:0] RF_S_ALU  = 2'b00;
    localparam logic [1:0] RF_S_DMEM = 2'b01;
    localparam logic [1:0] RF_S_IMM  = 2'b10;

    localparam int OP_HI      = 15;
    localparam int OP_LO      = 12;
    localparam int RA_HI      = 11;
    localparam int RA_LO      = 8;
    localparam int RB_HI      = 7;
    localparam int RB_LO      = 4;
    localparam int RD_HI      = 3;
    localparam int RD_LO      = 0;
    localparam int LD_ADDR_HI = 11;
    localparam int LD_ADDR_LO = 4;
    localparam int ST_ADDR_HI = 7;
    localparam int ST_ADDR_LO = 0;
    localparam int IMM_HI     = 11;
    localparam int IMM_LO     = 4;

    // Execute states are the ones that end an instruction and may divert to Wait.
    function automatic logic is_execute(state_e s);
        return (s == ST_NOOP) || (s == ST_LOADB) || (s == ST_STORE) ||
               (s == ST_ADD)  || (s == ST_SUB)   || (s == ST_LOADC);
    endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Bundle between the control unit and the datapath: IR/step inputs in, strobes/selects out.
interface proc_control_unit_if #(
    parameter int STATE_W = 8
);
    // No valid/ready handshake: every strobe is a level that is meaningful for exactly
    // the cycle it is high, and the datapath acts on it at the next rising Clk.
    logic [15:0]        IR;
    logic               Step_En;
    logic               Step;
    logic               PC_Clr;
    logic               PC_Up;
    logic               IR_Ld;
    logic [7:0]         D_Addr;
    logic               D_Wr;
    logic [1:0]         RF_s;
    logic [7:0]         RF_Imm;
    logic [3:0]         RF_W_Addr;
    logic               RF_W_En;
    logic [3:0]         RF_Ra_Addr;
    logic [3:0]         RF_Rb_Addr;
    logic [2:0]         ALU_Sel;
    logic               Halted;
    logic [STATE_W-1:0] State;
    logic [STATE_W-1:0] NextState;

    modport master (
        input  IR, Step_En, Step,
        output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_Imm, RF_W_Addr, RF_W_En,
               RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, Halted, State, NextState
    );

    modport slave (
        output IR, Step_En, Step,
        input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_Imm, RF_W_Addr, RF_W_En,
               RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, Halted, State, NextState
    );

endinterface

// File: rtl/proc_ir_decode.sv
// Combinational split of the instruction register into its opcode and operand fields.
module proc_ir_decode
    import proc_isa_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [3:0]  opcode_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [3:0]  rd_o,
    output logic [7:0]  ld_addr_o,
    output logic [7:0]  st_addr_o,
    output logic [7:0]  imm_o
);

    assign opcode_o  = ir_i[OP_HI:OP_LO];
    assign ra_o      = ir_i[RA_HI:RA_LO];
    assign rb_o      = ir_i[RB_HI:RB_LO];
    assign rd_o      = ir_i[RD_HI:RD_LO];
    assign ld_addr_o = ir_i[LD_ADDR_HI:LD_ADDR_LO];
    assign st_addr_o = ir_i[ST_ADDR_HI:ST_ADDR_LO];
    assign imm_o     = ir_i[IMM_HI:IMM_LO];

endmodule

// File: rtl/proc_control_unit.sv
// Moore control FSM sequencing Fetch -> Decode -> Execute for the 16-bit processor datapath,
// with single-step support and an absorbing Halt state.
module proc_control_unit
    import proc_isa_pkg::*;
#(
    parameter int STATE_W = 8,
    parameter int PC_W    = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    proc_control_unit_if.master ctrl
);

    if (STATE_W < 4 || PC_W < 1) begin : g_param_check
        $error("proc_control_unit: STATE_W must be >= 4 and PC_W >= 1");
    end

    state_e     state_q, state_d;
    logic [3:0] opcode, ra, rb, rd;
    logic [7:0] ld_addr, st_addr, imm;

    proc_ir_decode u_ir_decode (
        .ir_i      (ctrl.IR),
        .opcode_o  (opcode),
        .ra_o      (ra),
        .rb_o      (rb),
        .rd_o      (rd),
        .ld_addr_o (ld_addr),
        .st_addr_o (st_addr),
        .imm_o     (imm)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOADA;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_LOADC: state_d = ST_LOADC;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_LOADA:  state_d = ST_LOADB;
            ST_WAIT:   state_d = ctrl.Step ? ST_FETCH : ST_WAIT;
            ST_HALT:   state_d = ST_HALT;
            default: begin
                if (is_execute(state_q)) begin
                    state_d = ctrl.Step_En ? ST_WAIT : ST_FETCH;
                end else begin
                    state_d = ST_INIT;
                end
            end
        endcase
        if (Reset) begin
            state_d = ST_INIT;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend only on the registered state and the current IR fields.
    logic       pc_clr, pc_up, ir_ld, d_wr, rf_w_en, halted;
    logic [7:0] d_addr, rf_imm;
    logic [1:0] rf_s;
    logic [3:0] rf_w_addr, rf_ra_addr, rf_rb_addr;
    logic [2:0] alu_sel;

    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_wr       = 1'b0;
        rf_w_en    = 1'b0;
        halted     = 1'b0;
        d_addr     = 8'h00;
        rf_imm     = 8'h00;
        rf_s       = RF_S_ALU;
        rf_w_addr  = 4'h0;
        rf_ra_addr = 4'h0;
        rf_rb_addr = 4'h0;
        alu_sel    = ALU_ZERO;
        case (state_q)
            ST_INIT:  pc_clr = 1'b1;
            ST_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            // Present addresses one cycle early so synchronous RAM/RF reads land in Execute.
            ST_DECODE: begin
                case (opcode)
                    OP_STORE: begin
                        d_addr     = st_addr;
                        rf_ra_addr = ra;
                    end
                    OP_LOAD: d_addr = ld_addr;
                    OP_ADD, OP_SUB: begin
                        rf_ra_addr = ra;
                        rf_rb_addr = rb;
                    end
                    default: ;
                endcase
            end
            ST_LOADA: d_addr = ld_addr;
            ST_LOADB: begin
                d_addr    = ld_addr;
                rf_s      = RF_S_DMEM;
                rf_w_addr = rd;
                rf_w_en   = 1'b1;
            end
            ST_STORE: begin
                d_addr     = st_addr;
                rf_ra_addr = ra;
                d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                rf_ra_addr = ra;
                rf_rb_addr = rb;
                alu_sel    = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
                rf_s       = RF_S_ALU;
                rf_w_addr  = rd;
                rf_w_en    = 1'b1;
            end
            ST_LOADC: begin
                rf_s      = RF_S_IMM;
                rf_imm    = imm;
                rf_w_addr = rd;
                rf_w_en   = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign ctrl.PC_Clr     = pc_clr;
    assign ctrl.PC_Up      = pc_up;
    assign ctrl.IR_Ld      = ir_ld;
    assign ctrl.D_Addr     = d_addr;
    assign ctrl.D_Wr       = d_wr;
    assign ctrl.RF_s       = rf_s;
    assign ctrl.RF_Imm     = rf_imm;
    assign ctrl.RF_W_Addr  = rf_w_addr;
    assign ctrl.RF_W_En    = rf_w_en;
    assign ctrl.RF_Ra_Addr = rf_ra_addr;
    assign ctrl.RF_Rb_Addr = rf_rb_addr;
    assign ctrl.ALU_Sel    = alu_sel;
    assign ctrl.Halted     = halted;
    assign ctrl.State      = STATE_W'(state_q);
    assign ctrl.NextState  = STATE_W'(state_d);

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit: a per-cycle vector table through a full program,
// then hand-written Halt, single-step and mid-instruction reset sequences.
module tb_proc_control_unit;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    proc_control_unit_if #(.STATE_W(8)) bus ();

    proc_control_unit #(.STATE_W(8), .PC_W(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .ctrl  (bus)
    );

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic        se;
        logic        st;
        logic [7:0]  cur;
        logic [7:0]  nxt;
        logic [38:0] outs;
    } vec_t;

    localparam int NV = 27;
    vec_t vt[NV];

    // Packed order: PC_Clr PC_Up IR_Ld D_Addr D_Wr RF_s RF_Imm W_Addr W_En Ra Rb ALU Halted
    function automatic logic [38:0] o(logic pc_clr, logic pc_up, logic ir_ld, logic [7:0] d_addr,
                                      logic d_wr, logic [1:0] rf_s, logic [7:0] imm,
                                      logic [3:0] wa, logic we, logic [3:0] ra, logic [3:0] rb,
                                      logic [2:0] alu, logic halt);
        return {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, imm, wa, we, ra, rb, alu, halt};
    endfunction

    function automatic logic [38:0] act_outs();
        return {bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Addr, bus.D_Wr, bus.RF_s, bus.RF_Imm,
                bus.RF_W_Addr, bus.RF_W_En, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.ALU_Sel,
                bus.Halted};
    endfunction

    function automatic vec_t mkv(logic rst, logic [15:0] ir, logic se, logic st,
                                 logic [7:0] cur, logic [7:0] nxt, logic [38:0] outs);
        vec_t v;
        v.rst = rst; v.ir = ir; v.se = se; v.st = st; v.cur = cur; v.nxt = nxt; v.outs = outs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [7:0] tgt, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge Clk);
            if (bus.State == tgt) found = 1'b1;
            else begin
                @(posedge Clk);
                #1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s timeout actual_state=%h required_state=%h", name, bus.State, tgt);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
        @(negedge Clk);
    endtask

    initial begin
        logic [38:0] fet, none, pcc, hlt;
        fet  = o(0, 1, 1, 8'h00, 0, 2'd0, 8'h00, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
        none = '0;
        pcc  = o(1, 0, 0, 8'h00, 0, 2'd0, 8'h00, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
        hlt  = o(0, 0, 0, 8'h00, 0, 2'd0, 8'h00, 4'h0, 0, 4'h0, 4'h0, 3'd0, 1);

        vt[0]  = mkv(0, 16'h52A3, 0, 0, 8'h00, 8'h01, pcc);
        vt[1]  = mkv(0, 16'h52A3, 0, 0, 8'h01, 8'h02, fet);
        vt[2]  = mkv(0, 16'h52A3, 0, 0, 8'h02, 8'h0A, none);
        vt[3]  = mkv(0, 16'h52A3, 0, 0, 8'h0A, 8'h01,
                     o(0, 0, 0, 8'h00, 0, 2'b10, 8'h2A, 4'h3, 1, 4'h0, 4'h0, 3'd0, 0));
        vt[4]  = mkv(0, 16'h21B5, 0, 0, 8'h01, 8'h02, fet);
        vt[5]  = mkv(0, 16'h21B5, 0, 0, 8'h02, 8'h04,
                     o(0, 0, 0, 8'h1B, 0, 2'b00, 8'h00, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0));
        vt[6]  = mkv(0, 16'h21B5, 0, 0, 8'h04, 8'h05,
                     o(0, 0, 0, 8'h1B, 0, 2'b00, 8'h00, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0));
        vt[7]  = mkv(0, 16'h21B5, 0, 0, 8'h05, 8'h01,
                     o(0, 0, 0, 8'h1B, 0, 2'b01, 8'h00, 4'h5, 1, 4'h0, 4'h0, 3'd0, 0));
        vt[8]  = mkv(0, 16'h3124, 0, 0, 8'h01, 8'h02, fet);
        vt[9]  = mkv(0, 16'h3124, 0, 0, 8'h02, 8'h07,
                     o(0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 4'h0, 0, 4'h1, 4'h2, 3'd0, 0));
        vt[10] = mkv(0, 16'h3124, 0, 0, 8'h07, 8'h01,
                     o(0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 4'h4, 1, 4'h1, 4'h2, 3'b001, 0));
        vt[11] = mkv(0, 16'h4124, 0, 0, 8'h01, 8'h02, fet);
        vt[12] = mkv(0, 16'h4124, 0, 0, 8'h02, 8'h08,
                     o(0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 4'h0, 0, 4'h1, 4'h2, 3'd0, 0));
        vt[13] = mkv(0, 16'h4124, 0, 0, 8'h08, 8'h01,
                     o(0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 4'h4, 1, 4'h1, 4'h2, 3'b010, 0));
        vt[14] = mkv(0, 16'h1340, 0, 0, 8'h01, 8'h02, fet);
        vt[15] = mkv(0, 16'h1340, 0, 0, 8'h02, 8'h06,
                     o(0, 0, 0, 8'h40, 0, 2'b00, 8'h00, 4'h0, 0, 4'h3, 4'h0, 3'd0, 0));
        vt[16] = mkv(0, 16'h1340, 0, 0, 8'h06, 8'h01,
                     o(0, 0, 0, 8'h40, 1, 2'b00, 8'h00, 4'h0, 0, 4'h3, 4'h0, 3'd0, 0));
        vt[17] = mkv(0, 16'hF123, 0, 0, 8'h01, 8'h02, fet);
        vt[18] = mkv(0, 16'hF123, 0, 0, 8'h02, 8'h03, none);
        vt[19] = mkv(0, 16'hF123, 1, 0, 8'h03, 8'h0B, none);
        vt[20] = mkv(0, 16'hF123, 1, 0, 8'h0B, 8'h0B, none);
        vt[21] = mkv(0, 16'hF123, 1, 1, 8'h0B, 8'h01, none);
        vt[22] = mkv(0, 16'h6000, 0, 0, 8'h01, 8'h02, fet);
        vt[23] = mkv(0, 16'h6000, 0, 0, 8'h02, 8'h09, none);
        vt[24] = mkv(0, 16'h6000, 0, 1, 8'h09, 8'h09, hlt);
        vt[25] = mkv(1, 16'h6000, 0, 0, 8'h09, 8'h00, hlt);
        vt[26] = mkv(0, 16'h6000, 0, 0, 8'h00, 8'h01, pcc);

        // Clock/reset
        Reset       = 1'b1;
        bus.IR      = 16'h0000;
        bus.Step_En = 1'b0;
        bus.Step    = 1'b0;
        cycle();
        chk("reset_state", {56'd0, bus.State}, 64'h00);
        chk("reset_pc_clr", {63'd0, bus.PC_Clr}, 64'd1);
        @(posedge Clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            Reset       = vt[i].rst;
            bus.IR      = vt[i].ir;
            bus.Step_En = vt[i].se;
            bus.Step    = vt[i].st;
            @(negedge Clk);
            chk($sformatf("v%0d_state", i), {56'd0, bus.State}, {56'd0, vt[i].cur});
            chk($sformatf("v%0d_next", i), {56'd0, bus.NextState}, {56'd0, vt[i].nxt});
            chk($sformatf("v%0d_outs", i), {25'd0, act_outs()}, {25'd0, vt[i].outs});
            @(posedge Clk);
            #1;
        end

        // Halt is absorbing with Step toggling; only Reset leaves it.
        Reset = 1'b0; bus.IR = 16'h6000; bus.Step_En = 1'b0; bus.Step = 1'b0;
        wait_state(8'h09, "reach_halt");
        for (int i = 0; i < 20; i++) begin
            bus.Step = ~bus.Step;
            cycle();
            chk($sformatf("halt_hold%0d", i), {55'd0, bus.State, bus.Halted}, {55'd0, 8'h09, 1'b1});
        end
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        chk("halt_reset", {55'd0, bus.State, bus.PC_Clr}, {55'd0, 8'h00, 1'b1});

        // Single-step: Wait holds until Step.
        bus.Step_En = 1'b1; bus.Step = 1'b0; bus.IR = 16'h0000;
        wait_state(8'h03, "reach_noop");
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("wait_hold%0d", i), {56'd0, bus.State}, 64'h0B);
            chk($sformatf("wait_quiet%0d", i), {25'd0, act_outs()}, 64'd0);
        end
        bus.Step = 1'b1;
        cycle();
        chk("wait_release", {56'd0, bus.State}, 64'h01);
        bus.Step = 1'b0; bus.Step_En = 1'b0;

        // Reset during LoadA abandons the load: no RF write afterwards.
        bus.IR = 16'h21B5;
        wait_state(8'h04, "reach_loada");
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        bus.IR = 16'h0000;
        chk("loada_reset", {55'd0, bus.State, bus.RF_W_En}, {55'd0, 8'h00, 1'b0});
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("loada_no_wen%0d", i), {63'd0, bus.RF_W_En}, 64'd0);
        end

        // Reset on the Store edge: the write strobe for that cycle is still presented.
        bus.IR = 16'h1340;
        wait_state(8'h06, "reach_store");
        Reset = 1'b1;
        #1;
        chk("store_wr_presented", {63'd0, bus.D_Wr}, 64'd1);
        chk("store_reset_next", {56'd0, bus.NextState}, 64'h00);
        cycle();
        Reset = 1'b0;
        chk("store_reset", {55'd0, bus.State, bus.D_Wr}, {55'd0, 8'h00, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
